// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for a multicycle MIPS datapath. It decodes the instruction
//   opcode over several cycles and drives the datapath enables, the mux selects
//   and the 3-bit alu_op that feeds the ALU-function decoder. The FSM stalls in
//   the memory states until mem_ready is seen. It halts when it decodes an
//   unsupported opcode, or when a memory access waits longer than MEM_TIMEOUT.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-low reset
//   opcode[5:0]       instr[31:26] from IR, sampled in DECODE
//   mem_ready         memory completes the current read/write this cycle
//   pc_write          unconditional PC load
//   pc_write_cond_eq  PC load when ALU zero=1 (beq)
//   pc_write_cond_ne  PC load when ALU zero=0 (bne)
//   i_or_d            memory address select: 0=PC, 1=ALUOut
//   mem_read          memory read request
//   mem_write         memory write request
//   ir_write          IR load
//   mem_to_reg        RF write data select: 0=ALUOut, 1=MDR
//   reg_dst           RF destination select: 0=rt, 1=rd
//   reg_write         RF write enable
//   alu_src_a         ALU A select: 0=PC, 1=A
//   alu_src_b[1:0]    ALU B select: 00=B, 01=4, 10=imm, 11=imm<<2
//   pc_source[1:0]    PC source: 00=ALU result, 01=ALUOut, 10=jump target
//   alu_op[2:0]       111=R-type, 100=add, 101=or, 000=lui, 110=sub
//   illegal_op        sticky flag, set when an unsupported opcode is decoded
//   mem_timeout       sticky flag, set when a memory wait times out
//   state_out[3:0]    current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond_eq,
    output logic       pc_write_cond_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_out
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        ALU_WB = 4'd7,
        EXEC_I = 4'd8,
        IMM_WB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         op_q, op_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;

    logic in_mem_state;
    logic timeout_hit;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge. The reset branch sits
    // inside the clocked block, which makes the reset synchronous.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // The wait counter only runs in the three states that wait on memory.
    // A ready cycle completes the access even when the count is at its limit.
    assign in_mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout_hit  = in_mem_state && !mem_ready &&
                          (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: every signal assigned here gets a default first. A path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        illegal_d        = illegal_q;
        timeout_d        = timeout_q | timeout_hit;
        cnt_d            = (in_mem_state && !mem_ready && !timeout_hit) ? cnt_q + 1'b1 : '0;

        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        i_or_d           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_dst          = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = 2'b00;
        pc_source        = 2'b00;
        alu_op           = 3'b000;
        illegal_op       = illegal_q;
        mem_timeout      = timeout_q;
        state_out        = state_q;

        unique case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b100;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)        state_d = DECODE;
                else if (timeout_hit) state_d = HALT;
            end
            DECODE: begin
                // Compute the branch target into ALUOut in case it is needed.
                alu_src_b = 2'b11;
                alu_op    = 3'b100;
                op_d      = opcode;
                case (opcode)
                    OP_LW, OP_SW:           state_d = MEMADR;
                    OP_RTYPE:               state_d = EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = EXEC_I;
                    OP_BEQ, OP_BNE:         state_d = BRANCH;
                    OP_J:                   state_d = JUMP;
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b100;
                state_d   = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)        state_d = MEMWB;
                else if (timeout_hit) state_d = HALT;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready)        state_d = FETCH;
                else if (timeout_hit) state_d = HALT;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ORI:  alu_op = 3'b101;
                    OP_LUI:  alu_op = 3'b000;
                    default: alu_op = 3'b100;
                endcase
                state_d = IMM_WB;
            end
            IMM_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = 3'b110;
                pc_source        = 2'b01;
                pc_write_cond_eq = (op_q == OP_BEQ);
                pc_write_cond_ne = (op_q == OP_BNE);
                state_d          = FETCH;
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        // While reset is held, every output reads as zero whatever the state.
        if (!reset) begin
            pc_write         = 1'b0;
            pc_write_cond_eq = 1'b0;
            pc_write_cond_ne = 1'b0;
            i_or_d           = 1'b0;
            mem_read         = 1'b0;
            mem_write        = 1'b0;
            ir_write         = 1'b0;
            mem_to_reg       = 1'b0;
            reg_dst          = 1'b0;
            reg_write        = 1'b0;
            alu_src_a        = 1'b0;
            alu_src_b        = 2'b00;
            pc_source        = 2'b00;
            alu_op           = 3'b000;
            illegal_op       = 1'b0;
            mem_timeout      = 1'b0;
            state_out        = 4'd0;
        end
    end

endmodule
